// File: rtl/fp_burst_ldst_if.sv
// Bundle of the request handshake, FP register-file port and data-memory
// port used by the FP burst load/store engine.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both 1; all req_* fields are captured on that
// edge. req_ready is 1 only while the engine is idle. The requester may hold
// req_valid high for any number of cycles. The engine never acts on
// req_valid while req_ready is low.
interface fp_burst_ldst_if #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 3
);
  // Request side
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [LEN_W-1:0]  req_len;
  logic [31:0]       req_base;
  logic [15:0]       req_offset;
  logic [4:0]        req_freg;
  // FP register file side
  logic [4:0]        rf_rd_addr;
  logic [31:0]       rf_rd_data;
  logic              rf_we;
  logic [4:0]        rf_wr_addr;
  logic [31:0]       rf_wr_data;
  // Data memory side (active-low strobes)
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [31:0]       Data2Mem;
  logic [31:0]       ReadDataMem;
  // Completion
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_store, req_len, req_base, req_offset, req_freg,
    input  rf_rd_data, ReadDataMem,
    output req_ready, rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data,
    output CEN, WEN, OEN, A, Data2Mem, done, err
  );

  modport master (
    output req_valid, req_store, req_len, req_base, req_offset, req_freg,
    output rf_rd_data, ReadDataMem,
    input  req_ready, rf_rd_addr, rf_we, rf_wr_addr, rf_wr_data,
    input  CEN, WEN, OEN, A, Data2Mem, done, err
  );
endinterface

// File: rtl/fp_burst_ldst.sv
// FP burst load/store sequencer: moves 1..MAX_WORDS consecutive 32-bit words
// between the FP register file and a single-port data memory. Word k of the
// burst lives at word address base+k and maps to register freg+k. Misaligned
// addresses, bad lengths and register-range overflow are rejected with a
// done+err pulse and no access.
module fp_burst_ldst #(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 4,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_burst_ldst_if.slave        bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LOAD  = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [4:0]        freg_q, freg_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic              is_load_q, is_load_d;
  logic [ADDR_W-1:0] a_q, a_d;

  logic [31:0]       ea;
  logic [31:0]       reg_end;
  logic              req_bad;
  logic [ADDR_W-1:0] word_k;
  logic              last_word;

  // Effective byte address and request validity, evaluated at accept time.
  always_comb begin
    ea      = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
    reg_end = 32'(bus.req_freg) + 32'(bus.req_len);
    req_bad = (ea[1:0] != 2'b00) || (bus.req_len == '0) ||
              (32'(bus.req_len) > 32'(MAX_WORDS)) || (reg_end > 32'd32);
  end

  // Current word address (wraps silently) and last-word detect.
  always_comb begin
    word_k    = wbase_q + ADDR_W'(k_q);
    last_word = (k_q == len_q - LEN_W'(1));
  end

  // State and burst context registers; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      len_q     <= '0;
      freg_q    <= '0;
      wbase_q   <= '0;
      is_load_q <= 1'b0;
      a_q       <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      freg_q    <= freg_d;
      wbase_q   <= wbase_d;
      is_load_q <= is_load_d;
      a_q       <= a_d;
    end
  end

  // Next-state and output decode. Loads write register k-1 while reading
  // word k, so the final register write lands in FIN.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    len_d          = len_q;
    freg_d         = freg_q;
    wbase_d        = wbase_q;
    is_load_d      = is_load_q;
    a_d            = a_q;
    bus.req_ready  = 1'b0;
    bus.CEN        = 1'b1;
    bus.WEN        = 1'b1;
    bus.OEN        = 1'b1;
    bus.A          = a_q;
    bus.Data2Mem   = '0;
    bus.rf_rd_addr = '0;
    bus.rf_we      = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          len_d     = bus.req_len;
          freg_d    = bus.req_freg;
          wbase_d   = ADDR_W'(ea >> 2);
          is_load_d = !bus.req_store;
          k_d       = '0;
          if (req_bad)            state_d = S_ERR;
          else if (bus.req_store) state_d = S_STORE;
          else                    state_d = S_LOAD;
        end
      end
      S_STORE: begin
        bus.CEN        = 1'b0;
        bus.WEN        = 1'b0;
        bus.A          = word_k;
        a_d            = word_k;
        bus.rf_rd_addr = freg_q + 5'(k_q);
        bus.Data2Mem   = bus.rf_rd_data;
        k_d            = k_q + LEN_W'(1);
        if (last_word) state_d = S_FIN;
      end
      S_LOAD: begin
        bus.CEN = 1'b0;
        bus.OEN = 1'b0;
        bus.A   = word_k;
        a_d     = word_k;
        if (k_q != '0) begin
          bus.rf_we      = 1'b1;
          bus.rf_wr_addr = freg_q + 5'(k_q) - 5'd1;
          bus.rf_wr_data = bus.ReadDataMem;
        end
        k_d = k_q + LEN_W'(1);
        if (last_word) state_d = S_FIN;
      end
      S_FIN: begin
        bus.done = 1'b1;
        if (is_load_q) begin
          bus.rf_we      = 1'b1;
          bus.rf_wr_addr = freg_q + 5'(len_q) - 5'd1;
          bus.rf_wr_data = bus.ReadDataMem;
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_burst_ldst.sv
// Bench for fp_burst_ldst: memory and register-file environment, a
// transfer-level reference model producing a per-cycle expected trace,
// directed cases with literal expectations, and randomized traffic.
module tb_fp_burst_ldst;
  localparam int ADDR_W    = 7;
  localparam int MAX_WORDS = 4;
  localparam int LEN_W     = 3;
  localparam int DEPTH     = 1 << ADDR_W;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  fp_burst_ldst_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  fp_burst_ldst #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Environment: memory with one-cycle read latency and FP register file.
  logic [31:0] env_mem [DEPTH];
  logic [31:0] env_rf  [32];
  logic [31:0] rdata_q = '0;

  assign bus.rf_rd_data  = env_rf[bus.rf_rd_addr];
  assign bus.ReadDataMem = rdata_q;

  always @(posedge clk) begin
    if (!bus.CEN && !bus.WEN) env_mem[bus.A] <= bus.Data2Mem;
    if (!bus.CEN && !bus.OEN) rdata_q <= env_mem[bus.A];
    if (bus.rf_we) env_rf[bus.rf_wr_addr] <= bus.rf_wr_data;
  end

  // Reference model
  typedef struct packed {
    logic              ready;
    logic              cen;
    logic              wen;
    logic              oen;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d2m;
    logic [4:0]        rd_addr;
    logic              rf_we;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              done;
    logic              err;
  } obs_t;

  obs_t exp_q[$];
  logic [31:0]       ref_mem [DEPTH];
  logic [31:0]       ref_rf  [32];
  logic [ADDR_W-1:0] last_a;
  bit                pend_valid;
  bit                pend_store;
  int                pend_wb, pend_freg, pend_len;

  function automatic obs_t idle_obs(input logic [ADDR_W-1:0] a);
    obs_t o;
    o       = '0;
    o.ready = 1'b1;
    o.cen   = 1'b1;
    o.wen   = 1'b1;
    o.oen   = 1'b1;
    o.a     = a;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.ready   = bus.req_ready;
    o.cen     = bus.CEN;
    o.wen     = bus.WEN;
    o.oen     = bus.OEN;
    o.a       = bus.A;
    o.d2m     = bus.Data2Mem;
    o.rd_addr = bus.rf_rd_addr;
    o.rf_we   = bus.rf_we;
    o.wr_addr = bus.rf_wr_addr;
    o.wr_data = bus.rf_wr_data;
    o.done    = bus.done;
    o.err     = bus.err;
    return o;
  endfunction

  // Build the whole expected trace of one accepted request.
  task automatic model_accept();
    logic [31:0] ea;
    int   len, freg, wb;
    bit   bad, st;
    obs_t o;
    ea   = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
    len  = int'(bus.req_len);
    freg = int'(bus.req_freg);
    st   = bus.req_store;
    bad  = (ea[1:0] != 2'b00) || (len == 0) || (len > MAX_WORDS) || (freg + len > 32);
    if (bad) begin
      o       = idle_obs(last_a);
      o.ready = 1'b0;
      o.done  = 1'b1;
      o.err   = 1'b1;
      exp_q.push_back(o);
      exp_q.push_back(idle_obs(last_a));
      return;
    end
    wb = int'(ea[ADDR_W+1:2]);
    for (int c = 1; c <= len + 1; c++) begin
      o       = idle_obs('0);
      o.ready = 1'b0;
      if (c <= len) begin
        o.cen = 1'b0;
        o.a   = ADDR_W'((wb + c - 1) % DEPTH);
        if (st) begin
          o.wen     = 1'b0;
          o.d2m     = ref_rf[freg + c - 1];
          o.rd_addr = 5'(freg + c - 1);
        end else begin
          o.oen = 1'b0;
        end
      end else begin
        o.a    = ADDR_W'((wb + len - 1) % DEPTH);
        o.done = 1'b1;
      end
      if (!st && c >= 2) begin
        o.rf_we   = 1'b1;
        o.wr_addr = 5'(freg + c - 2);
        o.wr_data = ref_mem[(wb + c - 2) % DEPTH];
      end
      exp_q.push_back(o);
    end
    last_a = ADDR_W'((wb + len - 1) % DEPTH);
    exp_q.push_back(idle_obs(last_a));
    pend_valid = 1'b1;
    pend_store = st;
    pend_wb    = wb;
    pend_freg  = freg;
    pend_len   = len;
  endtask

  task automatic apply_pend();
    for (int k = 0; k < pend_len; k++) begin
      if (pend_store) ref_mem[(pend_wb + k) % DEPTH] = ref_rf[pend_freg + k];
      else            ref_rf[pend_freg + k] = ref_mem[(pend_wb + k) % DEPTH];
    end
    pend_valid = 1'b0;
  endtask

  // Model acceptance: the engine takes a request whenever it is idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      last_a     = '0;
      pend_valid = 1'b0;
    end else if (bus.req_valid && exp_q.size() == 0) begin
      model_accept();
    end
  end

  // Cycle compare against the model trace
  obs_t cmp_exp, cmp_act;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0) cmp_exp = exp_q.pop_front();
      else                   cmp_exp = idle_obs(last_a);
      cmp_act = sample_dut();
      tests++;
      if (cmp_act !== cmp_exp) begin
        fails++;
        $display("FAIL cycle t=%0t got=%h exp=%h", $time, cmp_act, cmp_exp);
      end
      if (cmp_exp.done && !cmp_exp.err && pend_valid) apply_pend();
    end
  end

  // Driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Present a request and wait (bounded) for the edge that accepts it.
  task automatic send(input logic st, input logic [LEN_W-1:0] len, input logic [31:0] base,
                      input logic [15:0] off, input logic [4:0] freg, input logic keep);
    bit ok;
    ok             = 1'b0;
    bus.req_store  = st;
    bus.req_len    = len;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_freg   = freg;
    bus.req_valid  = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    bus.req_valid = ok ? keep : 1'b0;
  endtask

  // Stimulus
  initial begin
    int mm;
    logic             r_st;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_base;
    logic [15:0]      r_off;
    logic [4:0]       r_freg;
    int               gap;

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_len    = '0;
    bus.req_base   = '0;
    bus.req_offset = '0;
    bus.req_freg   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < 32; i++) begin
      env_rf[i] = $urandom;
      ref_rf[i] = env_rf[i];
    end
    env_rf[4] = 32'h3FF0_0000; ref_rf[4] = 32'h3FF0_0000;
    env_rf[5] = 32'h0;         ref_rf[5] = 32'h0;
    env_mem[3] = 32'hDEAD_BEEF; ref_mem[3] = 32'hDEAD_BEEF;
    #1 rst = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_cen", 32'(bus.CEN), 32'd1);
    chk("rst_wen", 32'(bus.WEN), 32'd1);
    chk("rst_oen", 32'(bus.OEN), 32'd1);
    chk("rst_a", 32'(bus.A), 32'd0);
    chk("rst_d2m", bus.Data2Mem, 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("rst_wr_data", bus.rf_wr_data, 32'd0);
    chk("rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    // Store double
    send(1'b1, 3'd2, 32'h40, 16'd8, 5'd4, 1'b0);
    @(negedge clk);
    chk("sd_c1_a", 32'(bus.A), 32'h12);
    chk("sd_c1_wen", 32'(bus.WEN), 32'd0);
    chk("sd_c1_d2m", bus.Data2Mem, 32'h3FF0_0000);
    @(negedge clk);
    chk("sd_c2_a", 32'(bus.A), 32'h13);
    chk("sd_c2_d2m", bus.Data2Mem, 32'h0);
    @(negedge clk);
    chk("sd_c3_done", 32'(bus.done), 32'd1);
    chk("sd_c3_err", 32'(bus.err), 32'd0);
    @(negedge clk); #1;

    // Load single
    send(1'b0, 3'd1, 32'h10, 16'hFFFC, 5'd7, 1'b0);
    @(negedge clk);
    chk("ls_c1_a", 32'(bus.A), 32'd3);
    chk("ls_c1_oen", 32'(bus.OEN), 32'd0);
    chk("ls_c1_cen", 32'(bus.CEN), 32'd0);
    @(negedge clk);
    chk("ls_c2_we", 32'(bus.rf_we), 32'd1);
    chk("ls_c2_waddr", 32'(bus.rf_wr_addr), 32'd7);
    chk("ls_c2_wdata", bus.rf_wr_data, 32'hDEAD_BEEF);
    chk("ls_c2_done", 32'(bus.done), 32'd1);
    @(negedge clk); #1;

    // Misaligned
    send(1'b0, 3'd1, 32'h41, 16'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("mis_done", 32'(bus.done), 32'd1);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_cen", 32'(bus.CEN), 32'd1);
    chk("mis_rf_we", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    chk("mis_c2_cen", 32'(bus.CEN), 32'd1);
    #1;

    // Range errors
    send(1'b1, 3'd2, 32'h80, 16'd0, 5'd31, 1'b0);
    @(negedge clk);
    chk("freg_ovf_err", {30'd0, bus.done, bus.err}, 32'd3);
    chk("freg_ovf_cen", 32'(bus.CEN), 32'd1);
    @(negedge clk); #1;
    send(1'b0, 3'd0, 32'h80, 16'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("len0_err", {30'd0, bus.done, bus.err}, 32'd3);
    @(negedge clk); #1;
    send(1'b1, 3'd5, 32'h80, 16'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("len5_err", {30'd0, bus.done, bus.err}, 32'd3);
    chk("len5_cen", 32'(bus.CEN), 32'd1);
    @(negedge clk); #1;

    // Wrap plus back-to-back
    send(1'b0, 3'd2, 32'h1FC, 16'd0, 5'd10, 1'b1);
    bus.req_store = 1'b1;
    bus.req_len   = 3'd1;
    bus.req_base  = 32'h100;
    bus.req_freg  = 5'd2;
    @(negedge clk);
    chk("wr_c1_a", 32'(bus.A), 32'h7F);
    chk("wr_c1_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("wr_c2_a", 32'(bus.A), 32'h00);
    chk("wr_c2_waddr", {26'd0, bus.rf_we, bus.rf_wr_addr}, {26'd0, 1'b1, 5'd10});
    @(negedge clk);
    chk("wr_c3_waddr", {26'd0, bus.rf_we, bus.rf_wr_addr}, {26'd0, 1'b1, 5'd11});
    chk("wr_c3_done", 32'(bus.done), 32'd1);
    chk("wr_c3_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("wr_c4_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("wr_c5_ready", 32'(bus.req_ready), 32'd0);
    chk("wr_c5_cen", 32'(bus.CEN), 32'd0);
    chk("wr_c5_a", 32'(bus.A), 32'h40);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Reset mid-load
    send(1'b0, 3'd4, 32'h200, 16'd0, 5'd20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mr_cen", 32'(bus.CEN), 32'd1);
    chk("mr_oen", 32'(bus.OEN), 32'd1);
    chk("mr_rf_we", 32'(bus.rf_we), 32'd0);
    chk("mr_ready", 32'(bus.req_ready), 32'd1);
    chk("mr_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_done", 32'(bus.done), 32'd0);
    end
    #1;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_len  = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4)) : LEN_W'($urandom_range(0, 7));
      r_base = $urandom;
      if ($urandom_range(0, 9) != 0) r_base[1:0] = 2'b00;
      r_off  = 16'($urandom);
      if ($urandom_range(0, 9) != 0) r_off[1:0] = 2'b00;
      r_freg = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 28)) : 5'($urandom_range(0, 31));
      send(r_st, r_len, r_base, r_off, r_freg, 1'b0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        #1;
      end
    end

    repeat (10) @(negedge clk);
    mm = 0;
    for (int i = 0; i < DEPTH; i++) if (env_mem[i] !== ref_mem[i]) mm++;
    chk("mem_image_diffs", 32'(mm), 32'd0);
    mm = 0;
    for (int i = 0; i < 32; i++) if (env_rf[i] !== ref_rf[i]) mm++;
    chk("rf_image_diffs", 32'(mm), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_burst_ldst.md
# fp_burst_ldst

Parametrised floating-point load/store sequencer that moves 1 to MAX_WORDS consecutive 32-bit words between the FP register file and the single-port data memory. It generalises the single- and double-word FP memory operations (lwc1/swc1/ldc1/sdc1) into one handshaked, multi-cycle engine. The engine also adds alignment and register-range checking. It sits between the FP instruction decoder, which issues requests, and the data-memory port (CEN/WEN/OEN/A/Data2Mem/ReadDataMem).

## Interface
- ADDR_W, 7, data-memory word-address width (A width)
- MAX_WORDS, 4, maximum words per transfer (≥1)
- LEN_W, $clog2(MAX_WORDS+1), width of req_len

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  engine idle, can accept
- req_store  in  1  1 = store (reg→mem), 0 = load (mem→reg)
- req_len  in  LEN_W  word count
- req_base  in  32  byte base address (register value)
- req_offset  in  16  signed byte offset
- req_freg  in  5  first FP register index
- rf_rd_addr  out  5  FP regfile read index (combinational read)
- rf_rd_data  in  32  FP regfile read data, same cycle
- rf_we  out  1  FP regfile write enable
- rf_wr_addr  out  5  FP regfile write index
- rf_wr_data  out  32  FP regfile write data
- CEN  out  1  memory chip enable, active-low
- WEN  out  1  memory write enable, active-low
- OEN  out  1  memory output enable, active-low
- A  out  ADDR_W  memory word address
- Data2Mem  out  32  memory write data
- ReadDataMem  in  32  memory read data, valid the cycle after a read is presented
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: request rejected, no access made

## Operation
- Transfer starts on a rising edge with req_valid && req_ready. That edge captures all req_* fields.
- Byte address: ea = req_base + sign_extend(req_offset), 32-bit, with wrap.
- Word address of word k: ((ea >> 2) + k) mod 2^ADDR_W. Word k maps to register req_freg+k; the lowest address holds the lowest register.
- Error conditions: ea[1:0] ≠ 0, req_len = 0, req_len > MAX_WORDS, or req_freg + req_len > 32. On error: no memory access and no rf write; done=1 and err=1.
- States:
  - IDLE: req_ready=1. On accept, go to ERR if any error condition holds, else STORE or LOAD; counter k=0.
  - STORE: CEN=0, WEN=0, OEN=1, A=word k. rf_rd_addr=req_freg+k and Data2Mem=rf_rd_data. k increments each cycle. After word len-1, go to FIN.
  - LOAD: CEN=0, OEN=0, WEN=1, A=word k, k increments. From the second LOAD cycle on: rf_we=1, rf_wr_addr=req_freg+k-1, rf_wr_data=ReadDataMem. After word len-1, go to FIN.
  - FIN: done=1 and err=0. For loads, FIN also performs the last rf write: rf_we=1, rf_wr_addr=req_freg+len-1. FIN then returns to IDLE.
  - ERR: done=1, err=1, then IDLE.
- Outside STORE/LOAD: CEN=WEN=OEN=1, Data2Mem=0, A holds its last value.
- Outside LOAD/FIN-load: rf_we=0, rf_wr_addr=0, rf_wr_data=0.
- rf_rd_addr=0 outside STORE.

## Timing
- Let the accept edge be E0 and cycle cN the Nth cycle after E0.
- Store: memory writes in c1..cL; done in c(L+1).
- Load: reads presented in c1..cL; rf writes in c2..c(L+1); done in c(L+1).
- Error: done and err in c1.
- req_ready=0 from c1 through the done cycle. The next accept is possible at the edge ending the done cycle + 1, i.e. minimum request spacing is L+2 cycles.
- Reset values: state IDLE, req_ready=1, CEN=WEN=OEN=1, A=0, Data2Mem=0, rf_we=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr=0, done=0, err=0.
- Reset mid-transfer aborts immediately (asynchronously): no further memory or rf writes, and no done pulse.
- Address wrap modulo 2^ADDR_W is silent and is not an error.

## Test plan
- Store double: base=0x40, off=8, freg=4, len=2, F4=0x3FF00000, F5=0 -> c1: A=0x12, WEN=0, Data2Mem=0x3FF00000; c2: A=0x13, Data2Mem=0; c3: done=1, err=0.
- Load single: base=0x10, off=-4, freg=7, len=1, mem[3]=0xDEADBEEF -> c1: A=3, OEN=0, CEN=0; c2: rf_we=1, rf_wr_addr=7, rf_wr_data=0xDEADBEEF, done=1.
- Misaligned: base=0x41, off=0, len=1 -> c1: done=1, err=1; CEN stays 1 and rf_we stays 0 throughout.
- Range errors: each of the following -> done=1, err=1 in c1, no access:
  - freg=31, len=2
  - len=0
  - len=5 (MAX_WORDS=4)
- Wrap plus back-to-back: load base=0x1FC, len=2 -> A=0x7F then A=0x00, rf writes to freg and freg+1. A second request held valid is accepted at the end of c4 (the first done is in c3).
- Reset mid-load: len=4, assert rst during c2 -> same cycle: CEN=1, OEN=1, rf_we=0, req_ready=1; no done pulse; no writes after release.
